// File: rtl/axis_burst_scheduler.sv
// axis_burst_scheduler
//   Sequences an AXI-Stream data generator: enables it for a programmed
//   number of bursts with a programmable idle gap between bursts, and gates
//   its stream so that no beat escapes outside a scheduled burst.
//
// State | meaning
//   IDLE | waiting for start_i; gate closed, generator disabled
//   RUN  | burst in progress; gate open, generator enabled
//   GAP  | idle cycles between two bursts; gate closed
//
// Ports
//   clk_i, a_rst_n_i          clock, asynchronous active-low reset
//   start_i, abort_i          control pulses
//   burst_num_i, gap_len_i    burst count and inter-burst gap, latched on start
//   gen_enable_o              generator enable (high while in RUN)
//   s_axis_*                  stream from the generator
//   m_axis_*                  gated stream to downstream (zero latency)
//   busy_o, done_o, error_o   status (done is a one-cycle pulse, error sticky)
//   burst_cnt_o, beat_cnt_o   completed bursts, transferred beats (saturating)
module axis_burst_scheduler #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int BURST_CNT_WIDTH = 16,
  parameter int GAP_WIDTH       = 16,
  parameter int BEAT_CNT_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                         clk_i,
  input  logic                         a_rst_n_i,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic [BURST_CNT_WIDTH-1:0]   burst_num_i,
  input  logic [GAP_WIDTH-1:0]         gap_len_i,
  output logic                         gen_enable_o,
  input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata_i,
  input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep_i,
  input  logic                         s_axis_tvalid_i,
  input  logic                         s_axis_tlast_i,
  output logic                         s_axis_tready_o,
  output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata_o,
  output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep_o,
  output logic                         m_axis_tvalid_o,
  output logic                         m_axis_tlast_o,
  input  logic                         m_axis_tready_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         error_o,
  output logic [BURST_CNT_WIDTH-1:0]   burst_cnt_o,
  output logic [BEAT_CNT_WIDTH-1:0]    beat_cnt_o
);

  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t                       state_q;
  logic [BURST_CNT_WIDTH-1:0]   burst_num_q;
  logic [BURST_CNT_WIDTH-1:0]   burst_cnt_q;
  logic [BURST_CNT_WIDTH-1:0]   burst_cnt_d;
  logic [GAP_WIDTH-1:0]         gap_len_q;
  logic [GAP_WIDTH-1:0]         gap_cnt_q;
  logic [BEAT_CNT_WIDTH-1:0]    beat_cnt_q;
  logic [STALL_W-1:0]           stall_cnt_q;
  logic [STALL_W-1:0]           stall_cnt_d;
  logic                         done_q;
  logic                         error_q;
  logic                         gate_open;
  logic                         hs;

  assign gate_open = (state_q == S_RUN);
  assign hs        = s_axis_tvalid_i & m_axis_tready_i & gate_open;

  assign burst_cnt_d = burst_cnt_q + 1'b1;
  assign stall_cnt_d = stall_cnt_q + 1'b1;

  assign m_axis_tdata_o  = s_axis_tdata_i;
  assign m_axis_tkeep_o  = s_axis_tkeep_i;
  assign m_axis_tlast_o  = s_axis_tlast_i;
  assign m_axis_tvalid_o = s_axis_tvalid_i & gate_open;
  assign s_axis_tready_o = m_axis_tready_i & gate_open;

  assign gen_enable_o = gate_open;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign burst_cnt_o  = burst_cnt_q;
  assign beat_cnt_o   = beat_cnt_q;

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      state_q     <= S_IDLE;
      burst_num_q <= '0;
      burst_cnt_q <= '0;
      gap_len_q   <= '0;
      gap_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // The stall count only has meaning inside RUN; zero it everywhere else.
      if (state_q != S_RUN) stall_cnt_q <= '0;

      if (abort_i) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              burst_cnt_q <= '0;
              beat_cnt_q  <= '0;
              error_q     <= 1'b0;
              if (burst_num_i == '0) begin
                done_q <= 1'b1;
              end else begin
                burst_num_q <= burst_num_i;
                gap_len_q   <= gap_len_i;
                state_q     <= S_RUN;
              end
            end
          end

          S_RUN: begin
            stall_cnt_q <= s_axis_tvalid_i ? '0 : stall_cnt_d;
            if (hs) begin
              if (~&beat_cnt_q) beat_cnt_q <= beat_cnt_q + 1'b1;
              if (s_axis_tlast_i) begin
                burst_cnt_q <= burst_cnt_d;
                if (burst_cnt_d == burst_num_q) begin
                  state_q <= S_IDLE;
                  done_q  <= 1'b1;
                end else if (gap_len_q != '0) begin
                  // Down-counter: leaves GAP on the cycle it holds 1.
                  gap_cnt_q <= gap_len_q;
                  state_q   <= S_GAP;
                end
              end
            end else if (!s_axis_tvalid_i &&
                         stall_cnt_d == STALL_W'(TIMEOUT_CYCLES)) begin
              error_q <= 1'b1;
              state_q <= S_IDLE;
            end
          end

          S_GAP: begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
            if (gap_cnt_q == GAP_WIDTH'(1)) state_q <= S_RUN;
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_burst_scheduler.sv
module tb_axis_burst_scheduler;

  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int TO = 16;
  localparam longint MAXB = 64'hFFFF_FFFF;

  logic          clk_i = 1'b0;
  logic          a_rst_n_i;
  logic          start_i, abort_i;
  logic [15:0]   burst_num_i, gap_len_i;
  logic          gen_enable_o;
  logic [DW-1:0] s_axis_tdata_i;
  logic [KW-1:0] s_axis_tkeep_i;
  logic          s_axis_tvalid_i, s_axis_tlast_i, s_axis_tready_o;
  logic [DW-1:0] m_axis_tdata_o;
  logic [KW-1:0] m_axis_tkeep_o;
  logic          m_axis_tvalid_o, m_axis_tlast_o, m_axis_tready_i;
  logic          busy_o, done_o, error_o;
  logic [15:0]   burst_cnt_o;
  logic [31:0]   beat_cnt_o;

  always #5 clk_i = ~clk_i;

  axis_burst_scheduler #(
    .AXIS_DATA_WIDTH(DW), .BURST_CNT_WIDTH(16), .GAP_WIDTH(16),
    .BEAT_CNT_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .a_rst_n_i(a_rst_n_i), .start_i(start_i), .abort_i(abort_i),
    .burst_num_i(burst_num_i), .gap_len_i(gap_len_i), .gen_enable_o(gen_enable_o),
    .s_axis_tdata_i(s_axis_tdata_i), .s_axis_tkeep_i(s_axis_tkeep_i),
    .s_axis_tvalid_i(s_axis_tvalid_i), .s_axis_tlast_i(s_axis_tlast_i),
    .s_axis_tready_o(s_axis_tready_o), .m_axis_tdata_o(m_axis_tdata_o),
    .m_axis_tkeep_o(m_axis_tkeep_o), .m_axis_tvalid_o(m_axis_tvalid_o),
    .m_axis_tlast_o(m_axis_tlast_o), .m_axis_tready_i(m_axis_tready_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .burst_cnt_o(burst_cnt_o), .beat_cnt_o(beat_cnt_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = waiting, 1 = bursting, 2 = gap.
  int     md, mbnum, mgap, mgap_left, mstall, mbcnt;
  longint mbeats;
  bit     merr, mdone;

  // Generator model.
  int unsigned g_data;
  int g_beat, g_bsize, g_vmode, g_lowrun;

  // Per-test statistics.
  int done_cnt, en_cycles, gap_cycles;

  task automatic model_reset();
    md = 0; mbnum = 0; mgap = 0; mgap_left = 0; mstall = 0; mbcnt = 0;
    mbeats = 0; merr = 0; mdone = 0; g_beat = 0; g_lowrun = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_gen_en"}, gen_enable_o, 0);
    check_eq({tag, "_busy"}, busy_o, 0);
    check_eq({tag, "_done"}, done_o, 0);
    check_eq({tag, "_error"}, error_o, 0);
    check_eq({tag, "_tready"}, s_axis_tready_o, 0);
    check_eq({tag, "_tvalid"}, m_axis_tvalid_o, 0);
    check_eq({tag, "_bcnt"}, burst_cnt_o, 0);
    check_eq({tag, "_beats"}, beat_cnt_o, 0);
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle(input bit st, input bit ab, input int bnum_in, input int gap_in, input bit rdy);
    bit tv, tl, hs;
    check_eq("gen_enable", gen_enable_o, md == 1);
    check_eq("busy", busy_o, md != 0);
    check_eq("done", done_o, mdone);
    check_eq("error", error_o, merr);
    check_eq("burst_cnt", burst_cnt_o, mbcnt);
    check_eq("beat_cnt", beat_cnt_o, mbeats);

    if (g_vmode == 2)      tv = 1'b0;
    else if (gen_enable_o) tv = (g_vmode == 0) || (g_lowrun >= 3) || ($urandom_range(0, 3) != 0);
    else                   tv = $urandom_range(0, 1) != 0;  // leaky generator while disabled
    tl = (g_beat == g_bsize - 1);

    s_axis_tvalid_i = tv;
    s_axis_tdata_i  = g_data;
    s_axis_tkeep_i  = KW'($urandom);
    s_axis_tlast_i  = tl;
    m_axis_tready_i = rdy;
    start_i         = st;
    abort_i         = ab;
    burst_num_i     = 16'(bnum_in);
    gap_len_i       = 16'(gap_in);
    #1;
    check_eq("m_tvalid", m_axis_tvalid_o, tv && md == 1);
    check_eq("s_tready", s_axis_tready_o, rdy && md == 1);
    check_eq("m_tdata", m_axis_tdata_o, s_axis_tdata_i);
    check_eq("m_tkeep", m_axis_tkeep_o, s_axis_tkeep_i);
    check_eq("m_tlast", m_axis_tlast_o, tl);

    hs = tv && rdy && (md == 1);
    if (gen_enable_o && !tv) g_lowrun++; else g_lowrun = 0;
    if (hs) begin
      g_data++;
      g_beat = tl ? 0 : g_beat + 1;
    end
    if (md == 1) en_cycles++;
    if (md == 2) gap_cycles++;

    mdone = 0;
    if (ab) begin
      md = 0;
    end else if (md == 0) begin
      if (st) begin
        mbcnt = 0; mbeats = 0; merr = 0;
        if (bnum_in == 0) mdone = 1;
        else begin md = 1; mbnum = bnum_in; mgap = gap_in; mstall = 0; end
      end
    end else if (md == 1) begin
      if (tv) mstall = 0; else mstall++;
      if (hs) begin
        if (mbeats < MAXB) mbeats++;
        if (tl) begin
          mbcnt++;
          if (mbcnt == mbnum) begin md = 0; mdone = 1; end
          else if (mgap > 0) begin md = 2; mgap_left = mgap; end
        end
      end else if (mstall == TO) begin
        merr = 1; md = 0;
      end
    end else begin
      mgap_left--;
      if (mgap_left == 0) begin md = 1; mstall = 0; end
    end
    if (mdone) done_cnt++;

    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic begin_test(input int bsize, input int vmode);
    g_bsize = bsize; g_vmode = vmode; g_beat = 0; g_lowrun = 0;
    done_cnt = 0; en_cycles = 0; gap_cycles = 0;
  endtask

  task automatic run_bursts(input string tag, input int bnum, input int gap, input int bsize,
                            input int vmode, input bit rnd_rdy, input int budget);
    begin_test(bsize, vmode);
    cycle(1, 0, bnum, gap, 1);
    for (int c = 0; c < budget && md != 0; c++)
      cycle(0, 0, 0, 0, rnd_rdy ? ($urandom_range(0, 1) != 0) : 1'b1);
    check_eq({tag, "_in_budget"}, md, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    check_eq({tag, "_bursts"}, burst_cnt_o, bnum);
    check_eq({tag, "_beats_total"}, beat_cnt_o, bnum * bsize);
    check_eq({tag, "_done_pulses"}, done_cnt, 1);
    check_eq({tag, "_gap_cycles"}, gap_cycles, (bnum > 0) ? (bnum - 1) * gap : 0);
    check_eq({tag, "_error_clear"}, error_o, 0);
    check_eq({tag, "_gen_off"}, gen_enable_o, 0);
  endtask

  initial begin
    a_rst_n_i = 1'b0;
    start_i = 0; abort_i = 0; burst_num_i = 0; gap_len_i = 0;
    s_axis_tdata_i = 0; s_axis_tkeep_i = 0; s_axis_tvalid_i = 0; s_axis_tlast_i = 0;
    m_axis_tready_i = 1;
    g_data = 32'h1000;
    model_reset();
    @(negedge clk_i);
    #1;
    check_reset_outputs("reset");
    @(negedge clk_i);
    a_rst_n_i = 1'b1;
    @(negedge clk_i);

    // Three back-to-back bursts of 99 beats, ready tied high.
    run_bursts("b2b", 3, 0, 99, 0, 0, 400);

    // Two bursts with a 5-cycle gap, random valid and ready.
    run_bursts("gap5", 2, 5, 99, 1, 1, 2000);

    // Zero bursts: done the cycle after start, generator never enabled.
    run_bursts("zero", 0, 3, 4, 0, 0, 10);
    check_eq("zero_en_cycles", en_cycles, 0);

    // Abort at beat 50 of the second burst.
    begin_test(99, 0);
    cycle(1, 0, 4, 0, 1);
    for (int c = 0; c < 400 && mbeats < 149; c++) cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0);
    check_eq("abort_idle", busy_o, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    check_eq("abort_bcnt", burst_cnt_o, 1);
    check_eq("abort_beats", beat_cnt_o, 149);
    check_eq("abort_no_done", done_cnt, 0);
    check_eq("abort_gen_off", gen_enable_o, 0);

    // Stalled generator: error after exactly TO cycles of RUN.
    begin_test(4, 2);
    cycle(1, 0, 1, 0, 1);
    for (int c = 0; c < 100 && md != 0; c++) cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    check_eq("stall_error", error_o, 1);
    check_eq("stall_run_cycles", en_cycles, TO);
    check_eq("stall_no_done", done_cnt, 0);
    begin_test(3, 0);
    cycle(1, 0, 1, 0, 1);
    check_eq("restart_clears_error", error_o, 0);
    run_bursts("after_stall", 1, 0, 3, 0, 0, 50);

    // Held start while busy is ignored; then async reset mid-burst.
    begin_test(10, 0);
    cycle(1, 0, 3, 2, 1);
    for (int c = 0; c < 100 && mbeats < 15; c++) cycle(1, 0, 7, 0, 1);
    check_eq("held_start_busy", busy_o, 1);
    check_eq("held_start_bcnt", burst_cnt_o, 1);
    s_axis_tvalid_i = 1'b1;
    m_axis_tready_i = 1'b1;
    start_i = 1'b0;
    a_rst_n_i = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    a_rst_n_i = 1'b1;
    run_bursts("post_rst", 2, 1, 4, 1, 1, 200);

    // Randomized configurations.
    for (int i = 0; i < 6; i++)
      run_bursts("rand", $urandom_range(1, 3), $urandom_range(0, 4), $urandom_range(1, 6), 1, 1, 400);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
